alu_issue_ctrl: RTL and testbench

- Initiator side of the ALU operand/control interface.
- Accepts a decoded-instruction request (ALUOp, funct3, funct7[5], opcode[5], operands) over a valid/ready handshake and decodes it to the 4-bit ALU control code.
- Drives operands and control to the combinational ALU, captures result and zero flag, and returns them over a valid/ready response channel.
- Used by the multi-cycle datapath as the single owner of the ALU.

---
 rtl/alu_issue_ctrl.sv | 144 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Initiator-side ALU issue controller: decodes a request, drives the ALU, returns its result.
// Optional macro ALU_ISSUE_NOR_EN adds the NOR encoding (ALUOp 10, funct3 100, funct7[5] 1).
module alu_issue_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_alu_op,
  input  logic [2:0]       req_funct3,
  input  logic             req_funct7_5,
  input  logic             req_op_5,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_illegal,
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [3:0]       alu_ctrl_q;
  logic [WIDTH-1:0] rsp_result_q;
  logic             rsp_zero_q, rsp_illegal_q, rsp_valid_q;
  logic [CNT_W-1:0] op_count_q;

  logic       dec_legal;
  logic [3:0] dec_ctrl;
  logic       accept, load_op, load_ill, capture, rsp_done;

  // Returns {legal, ctrl}
  function automatic logic [4:0] decode(input logic [1:0] op, input logic [2:0] f3,
                                        input logic f7_5, input logic op_5);
    logic [4:0] r;
    r = 5'b0_0000;
    unique case (op)
      2'b00: r = 5'b1_0010;
      2'b01: r = 5'b1_0110;
      2'b10: begin
        unique case (f3)
          3'b000: r = (f7_5 & op_5) ? 5'b1_0110 : 5'b1_0010;
          3'b111: r = 5'b1_0000;
          3'b110: r = 5'b1_0001;
          3'b010: r = 5'b1_0111;
`ifdef ALU_ISSUE_NOR_EN
          3'b100: r = f7_5 ? 5'b1_1100 : 5'b0_0000;
`endif
          default: r = 5'b0_0000;
        endcase
      end
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    {dec_legal, dec_ctrl} = decode(req_alu_op, req_funct3, req_funct7_5, req_op_5);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = dec_legal ? ISSUE : RESP;
      ISSUE:   state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state_q == IDLE);
    accept    = req_ready & req_valid;
    load_op   = accept & dec_legal;
    load_ill  = accept & ~dec_legal;
    capture   = (state_q == ISSUE);
    rsp_done  = (state_q == RESP) & rsp_ready;
  end

  // Illegal requests bypass the ALU so its operands keep the last legal values
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_ctrl_q    <= '0;
      rsp_result_q  <= '0;
      rsp_zero_q    <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_valid_q   <= 1'b0;
      op_count_q    <= '0;
    end else begin
      if (load_op) begin
        alu_a_q    <= req_a;
        alu_b_q    <= req_b;
        alu_ctrl_q <= dec_ctrl;
      end
      if (load_ill) begin
        rsp_result_q  <= '0;
        rsp_zero_q    <= 1'b0;
        rsp_illegal_q <= 1'b1;
        rsp_valid_q   <= 1'b1;
      end else if (capture) begin
        rsp_result_q  <= alu_result;
        rsp_zero_q    <= alu_zero;
        rsp_illegal_q <= 1'b0;
        rsp_valid_q   <= 1'b1;
        op_count_q    <= sat_inc(op_count_q);
      end else if (rsp_done) begin
        rsp_valid_q   <= 1'b0;
      end
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_illegal = rsp_illegal_q;
  assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl with a behavioural ALU; counter built narrow so saturation is reachable.
module tb_alu_issue_ctrl;
  localparam int W      = 32;
  localparam int TB_CNT = 6;
  localparam int CMAX   = (1 << TB_CNT) - 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid, req_ready;
  logic [1:0]    req_alu_op;
  logic [2:0]    req_funct3;
  logic          req_funct7_5, req_op_5;
  logic [W-1:0]  req_a, req_b;
  logic [W-1:0]  alu_a, alu_b, alu_result;
  logic [3:0]    alu_ctrl;
  logic          alu_zero;
  logic          rsp_valid, rsp_ready, rsp_zero, rsp_illegal;
  logic [W-1:0]  rsp_result;
  logic [TB_CNT-1:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  logic [3:0] last_ctrl = 4'h0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(W), .CNT_W(TB_CNT)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_alu_op(req_alu_op), .req_funct3(req_funct3), .req_funct7_5(req_funct7_5),
    .req_op_5(req_op_5), .req_a(req_a), .req_b(req_b), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_illegal(rsp_illegal), .op_count(op_count));

  // Combinational ALU seen by the DUT
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      4'b0010: alu_result = alu_a + alu_b;
      4'b0110: alu_result = alu_a - alu_b;
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0111: alu_result = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == '0);

  typedef enum {K_ADD, K_SUB, K_AND, K_OR, K_SLT, K_NOR, K_ILL} kind_t;

  typedef struct {
    logic [1:0] op; logic [2:0] f3; logic f7; logic o5;
    logic [31:0] a; logic [31:0] b; int hold;
    logic [3:0] ctrl; logic [31:0] res; logic z; logic ill;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                input logic o5, input logic [31:0] a, input logic [31:0] b,
                                output logic ill, output logic [3:0] ctrl, output logic [31:0] res);
    kind_t k;
    k = K_ILL;
    if (op == 2'd0) k = K_ADD;
    else if (op == 2'd1) k = K_SUB;
    else if (op == 2'd2) begin
      if (f3 == 3'd0) k = (f7 && o5) ? K_SUB : K_ADD;
      else if (f3 == 3'd7) k = K_AND;
      else if (f3 == 3'd6) k = K_OR;
      else if (f3 == 3'd2) k = K_SLT;
`ifdef ALU_ISSUE_NOR_EN
      else if (f3 == 3'd4 && f7) k = K_NOR;
`endif
    end
    ill = (k == K_ILL);
    ctrl = last_ctrl;
    res = 32'd0;
    case (k)
      K_ADD: begin ctrl = 4'd2;  res = a + b; end
      K_SUB: begin ctrl = 4'd6;  res = a - b; end
      K_AND: begin ctrl = 4'd0;  res = a & b; end
      K_OR:  begin ctrl = 4'd1;  res = a | b; end
      K_SLT: begin ctrl = 4'd7;  res = (int'(a) < int'(b)) ? 32'd1 : 32'd0; end
      K_NOR: begin ctrl = 4'd12; res = ~(a | b); end
      default: ;
    endcase
  endfunction

  task automatic drive_req(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                           input logic o5, input logic [31:0] a, input logic [31:0] b);
    req_alu_op = op; req_funct3 = f3; req_funct7_5 = f7; req_op_5 = o5;
    req_a = a; req_b = b; req_valid = 1'b1;
  endtask

  // Presents a request, waits for the response, holds rsp_ready low for 'hold' cycles.
  task automatic run_op(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                        input logic o5, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output int lat, output logic [31:0] res,
                        output logic z, output logic ill, output logic [3:0] ctrl);
    int waited;
    @(negedge clk);
    drive_req(op, f3, f7, o5, a, b);
    waited = 0;
    while (!req_ready && waited < 8) begin @(negedge clk); waited++; end
    chk("req_ready_idle", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 8) begin @(negedge clk); lat++; end
    if (!rsp_valid) lat = 99;
    res = rsp_result; z = rsp_zero; ill = rsp_illegal; ctrl = alu_ctrl;
    for (int h = 0; h < hold; h++) begin
      drive_req($urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
      @(negedge clk);
      chk("hold_valid", rsp_valid, 1);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_result", rsp_result, res);
      chk("hold_flags", {rsp_zero, rsp_illegal}, {z, ill});
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done_valid", rsp_valid, 0);
    chk("rsp_done_idle", req_ready, 1);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_alu"}, {alu_a, alu_b, alu_ctrl}, 0);
    chk({tag, "_rsp"}, {rsp_valid, rsp_result, rsp_zero, rsp_illegal}, 0);
    chk({tag, "_cnt"}, op_count, 0);
    chk({tag, "_ready"}, req_ready, 1);
  endtask

  task automatic apply_and_check(input string tag, input logic [1:0] op, input logic [2:0] f3,
                                 input logic f7, input logic o5, input logic [31:0] a,
                                 input logic [31:0] b, input int hold, input logic [3:0] ectrl,
                                 input logic [31:0] eres, input logic ez, input logic eill);
    int lat; logic [31:0] res; logic z, ill; logic [3:0] ctrl;
    run_op(op, f3, f7, o5, a, b, hold, lat, res, z, ill, ctrl);
    chk({tag, "_latency"}, lat, eill ? 1 : 2);
    chk({tag, "_illegal"}, ill, eill);
    chk({tag, "_result"}, res, eres);
    chk({tag, "_zero"}, z, ez);
    chk({tag, "_ctrl"}, ctrl, ectrl);
    if (!eill) begin
      last_ctrl = ectrl;
      if (exp_cnt < CMAX) exp_cnt++;
    end
    chk({tag, "_count"}, op_count, exp_cnt);
  endtask

  initial begin
    logic [1:0] op; logic [2:0] f3; logic f7, o5; logic [31:0] a, b;
    logic eill; logic [3:0] ectrl; logic [31:0] eres;
    int guard;

    tbl[0]  = '{2'b10, 3'b000, 1'b0, 1'b1, 32'd5,        32'd7,        0, 4'd2,  32'd12,       1'b0, 1'b0};
    tbl[1]  = '{2'b10, 3'b000, 1'b1, 1'b1, 32'h1234,     32'h1234,     1, 4'd6,  32'd0,        1'b1, 1'b0};
    tbl[2]  = '{2'b10, 3'b000, 1'b1, 1'b0, 32'h1234,     32'h1234,     0, 4'd2,  32'h2468,     1'b0, 1'b0};
    tbl[3]  = '{2'b10, 3'b010, 1'b0, 1'b1, 32'd3,        32'd9,        5, 4'd7,  32'd1,        1'b0, 1'b0};
    tbl[4]  = '{2'b11, 3'b000, 1'b0, 1'b1, 32'd44,       32'd55,       2, 4'd7,  32'd0,        1'b0, 1'b1};
    tbl[5]  = '{2'b10, 3'b111, 1'b0, 1'b1, 32'hFF00FF00, 32'h0F0F0F0F, 0, 4'd0,  32'h0F000F00, 1'b0, 1'b0};
    tbl[6]  = '{2'b10, 3'b110, 1'b0, 1'b1, 32'hFF00FF00, 32'h0F0F0F0F, 0, 4'd1,  32'hFF0FFF0F, 1'b0, 1'b0};
    tbl[7]  = '{2'b00, 3'b101, 1'b1, 1'b0, 32'hFFFFFFFF, 32'd1,        0, 4'd2,  32'd0,        1'b1, 1'b0};
    tbl[8]  = '{2'b01, 3'b111, 1'b0, 1'b1, 32'd3,        32'd5,        0, 4'd6,  32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[9]  = '{2'b10, 3'b010, 1'b0, 1'b1, 32'hFFFFFFFF, 32'd1,        0, 4'd7,  32'd1,        1'b0, 1'b0};
    tbl[10] = '{2'b10, 3'b001, 1'b0, 1'b1, 32'd8,        32'd8,        1, 4'd7,  32'd0,        1'b0, 1'b1};
`ifdef ALU_ISSUE_NOR_EN
    tbl[11] = '{2'b10, 3'b100, 1'b1, 1'b1, 32'h0F0F0F0F, 32'hF0F00000, 0, 4'd12, 32'h0000F0F0, 1'b0, 1'b0};
`else
    tbl[11] = '{2'b10, 3'b100, 1'b1, 1'b1, 32'h0F0F0F0F, 32'hF0F00000, 0, 4'd7,  32'd0,        1'b0, 1'b1};
`endif

    rst_n = 1'b0; rsp_ready = 1'b0;
    drive_req(2'b00, 3'b000, 1'b0, 1'b0, 32'd0, 32'd0);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("reset");

    foreach (tbl[i])
      apply_and_check($sformatf("vec%0d", i), tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].o5,
                      tbl[i].a, tbl[i].b, tbl[i].hold, tbl[i].ctrl, tbl[i].res, tbl[i].z, tbl[i].ill);

    // Reset while the ALU is settling drops the transaction
    @(negedge clk);
    drive_req(2'b10, 3'b000, 1'b0, 1'b1, 32'd100, 32'd23);
    @(negedge clk);
    req_valid = 1'b0;
    chk("issue_no_rsp_yet", rsp_valid, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_reset_state("midreset");
    exp_cnt = 0; last_ctrl = 4'h0;
    repeat (3) @(negedge clk);
    chk("midreset_no_rsp", rsp_valid, 0);

    for (int n = 0; n < 150; n++) begin
      op = 2'($urandom_range(0, 3)); f3 = 3'($urandom_range(0, 7));
      f7 = 1'($urandom); o5 = 1'($urandom);
      a = $urandom; b = ($urandom_range(0, 4) == 0) ? a : $urandom;
      model(op, f3, f7, o5, a, b, eill, ectrl, eres);
      apply_and_check($sformatf("rnd%0d", n), op, f3, f7, o5, a, b, $urandom_range(0, 2),
                      ectrl, eres, (eres == 0) && !eill, eill);
    end

    guard = 0;
    while (exp_cnt < CMAX && guard < 80) begin
      apply_and_check("fill", 2'b00, 3'b000, 1'b0, 1'b0, 32'd1, 32'd2, 0, 4'd2, 32'd3, 1'b0, 1'b0);
      guard++;
    end
    chk("count_at_max", op_count, CMAX);
    apply_and_check("sat", 2'b00, 3'b000, 1'b0, 1'b0, 32'd4, 32'd4, 0, 4'd2, 32'd8, 1'b0, 1'b0);
    chk("count_saturated", op_count, CMAX);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
